// File: rtl/lstm_ctrl_pkg.sv
// Shared state type and default sizing for the LSTM cell/hidden-state memory pass.
// SEQ_STOP is the total address span covered by one full sequence.
package lstm_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      DRAIN,
      STEP,
      DONE
   } ctrl_state_t;

   localparam int N_HIDDEN   = 53;
   localparam int TIMESTEP   = 7;
   localparam int ADDR_WIDTH = 12;
   localparam int DELAY      = 1;
   localparam int SEQ_STOP   = TIMESTEP * N_HIDDEN;

endpackage

// File: rtl/lstm_cell_step_ctrl_if.sv
// Scheduler/memory-side bundle of the step controller: handshake, stall,
// read strobes with cell/hidden addresses, and the cell-state write-back.
interface lstm_cell_step_ctrl_if #(
   parameter int ADDR_WIDTH = 12
);

   logic                  start;
   logic                  stall;
   logic                  busy;
   logic                  done;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr_c;
   logic [ADDR_WIDTH-1:0] rd_addr_h;
   logic                  h_zero;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [7:0]            step_idx;

   modport slave (
      input  start,
      input  stall,
      output busy,
      output done,
      output rd_en,
      output rd_addr_c,
      output rd_addr_h,
      output h_zero,
      output wr_en,
      output wr_addr,
      output step_idx
   );

   modport master (
      output start,
      output stall,
      input  busy,
      input  done,
      input  rd_en,
      input  rd_addr_c,
      input  rd_addr_h,
      input  h_zero,
      input  wr_en,
      input  wr_addr,
      input  step_idx
   );

endinterface

// File: rtl/lstm_cell_step_ctrl_wr_pipe.sv
// DEPTH-deep {valid, addr} shift register that matches the datapath latency
// between a read and its write-back; it only moves when advance is high.
module step_wr_pipe #(
   parameter int DEPTH      = 1,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  advance,
   input  logic                  push,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic                  tail_valid,
   output logic [ADDR_WIDTH-1:0] tail_addr
);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic                  in_valid;
         logic [ADDR_WIDTH-1:0] in_addr;
         logic                  valid_reg;
         logic [ADDR_WIDTH-1:0] addr_reg;

         if (gi == 0) begin : g_head
            assign in_valid = push;
            assign in_addr  = addr;
         end else begin : g_body
            assign in_valid = g_stage[gi-1].valid_reg;
            assign in_addr  = g_stage[gi-1].addr_reg;
         end

         // Bubbles leave the address untouched so the tail keeps the last real write address.
         always_ff @(posedge clk) begin
            if (rst) begin
               valid_reg <= 1'b0;
               addr_reg  <= '0;
            end else if (advance) begin
               valid_reg <= in_valid;
               if (in_valid) begin
                  addr_reg <= in_addr;
               end
            end
         end
      end
   endgenerate

   assign tail_valid = g_stage[DEPTH-1].valid_reg;
   assign tail_addr  = g_stage[DEPTH-1].addr_reg;

endmodule

// File: rtl/lstm_cell_step_ctrl.sv
// Walks every hidden unit of every timestep, issuing cell/hidden-state reads
// and the delayed cell-state write-back, with a start/busy/done handshake.
module lstm_cell_step_ctrl #(
   parameter int ADDR_WIDTH = lstm_ctrl_pkg::ADDR_WIDTH,
   parameter int N_HIDDEN   = lstm_ctrl_pkg::N_HIDDEN,
   parameter int TIMESTEP   = lstm_ctrl_pkg::TIMESTEP,
   parameter int DELAY      = lstm_ctrl_pkg::DELAY
) (
   input  logic                 clk,
   input  logic                 rst,
   lstm_cell_step_ctrl_if.slave bus
);

   import lstm_ctrl_pkg::ctrl_state_t;
   import lstm_ctrl_pkg::IDLE;
   import lstm_ctrl_pkg::RUN;
   import lstm_ctrl_pkg::DRAIN;
   import lstm_ctrl_pkg::STEP;
   import lstm_ctrl_pkg::DONE;

   localparam logic [ADDR_WIDTH-1:0] LAST_ROW   = ADDR_WIDTH'(N_HIDDEN - 1);
   localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(N_HIDDEN);
   localparam logic [7:0]            LAST_STEP  = 8'(TIMESTEP - 1);
   localparam logic [3:0]            LAST_DRAIN = 4'(DELAY - 1);

   ctrl_state_t           state_reg, state_next;
   logic [ADDR_WIDTH-1:0] row_reg, row_next;
   logic [ADDR_WIDTH-1:0] base_reg, base_next;
   logic [7:0]            step_reg, step_next;
   logic [3:0]            drain_reg, drain_next;

   logic                  push;
   logic                  tail_valid;
   logic [ADDR_WIDTH-1:0] tail_addr;
   logic [ADDR_WIDTH-1:0] rd_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         row_reg   <= '0;
         base_reg  <= '0;
         step_reg  <= '0;
         drain_reg <= '0;
      end else begin
         state_reg <= state_next;
         row_reg   <= row_next;
         base_reg  <= base_next;
         step_reg  <= step_next;
         drain_reg <= drain_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      row_next   = row_reg;
      base_next  = base_reg;
      step_next  = step_reg;
      drain_next = drain_reg;
      push       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               state_next = RUN;
               row_next   = '0;
               base_next  = '0;
               step_next  = '0;
               drain_next = '0;
            end
         end
         RUN: begin
            if (!bus.stall) begin
               push = 1'b1;
               if (row_reg == LAST_ROW) begin
                  state_next = DRAIN;
                  row_next   = '0;
                  drain_next = '0;
               end else begin
                  row_next = row_reg + 1'b1;
               end
            end
         end
         DRAIN: begin
            // DELAY unstalled cycles flush the last row's write out of the pipe.
            if (!bus.stall) begin
               if (drain_reg == LAST_DRAIN) begin
                  state_next = (step_reg == LAST_STEP) ? DONE : STEP;
                  drain_next = '0;
               end else begin
                  drain_next = drain_reg + 1'b1;
               end
            end
         end
         STEP: begin
            base_next  = base_reg + ROW_STRIDE;
            step_next  = step_reg + 1'b1;
            state_next = RUN;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   step_wr_pipe #(
      .DEPTH      (DELAY),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_wr_pipe (
      .clk        (clk),
      .rst        (rst),
      .advance    (~bus.stall),
      .push       (push),
      .addr       (rd_addr),
      .tail_valid (tail_valid),
      .tail_addr  (tail_addr)
   );

   assign rd_addr       = base_reg + row_reg;

   assign bus.busy      = (state_reg != IDLE);
   assign bus.done      = (state_reg == DONE);
   assign bus.rd_en     = (state_reg == RUN) & ~bus.stall;
   assign bus.rd_addr_c = rd_addr;
   // Step 0 has no previous hidden state; the datapath substitutes zero.
   assign bus.rd_addr_h = (step_reg == 8'd0) ? '0 : (rd_addr - ROW_STRIDE);
   assign bus.h_zero    = (state_reg != IDLE) && (step_reg == 8'd0);
   assign bus.wr_en     = tail_valid & ~bus.stall;
   assign bus.wr_addr   = tail_addr;
   assign bus.step_idx  = step_reg;

endmodule

// File: tb/tb_lstm_cell_step_ctrl.sv
// Bench for lstm_cell_step_ctrl: two configurations driven with directed and
// random stall, checked cycle by cycle against a slot/queue model of the sequence.
module tb_lstm_cell_step_ctrl;

   import lstm_ctrl_pkg::SEQ_STOP;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sel = 1'b0;
   logic start_v = 1'b0;
   logic stall_v = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   always #5 clk = ~clk;

   lstm_cell_step_ctrl_if #(.ADDR_WIDTH(12)) bus_a ();
   lstm_cell_step_ctrl_if #(.ADDR_WIDTH(12)) bus_b ();

   lstm_cell_step_ctrl #(.ADDR_WIDTH(12), .N_HIDDEN(53), .TIMESTEP(7), .DELAY(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   lstm_cell_step_ctrl #(.ADDR_WIDTH(12), .N_HIDDEN(5), .TIMESTEP(2), .DELAY(4)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   assign bus_a.start = start_v & ~sel;
   assign bus_a.stall = stall_v & ~sel;
   assign bus_b.start = start_v & sel;
   assign bus_b.stall = stall_v & sel;

   logic        obs_busy, obs_done, obs_rd_en, obs_h_zero, obs_wr_en;
   logic [11:0] obs_rd_addr_c, obs_rd_addr_h, obs_wr_addr;
   logic [7:0]  obs_step_idx;

   assign obs_busy      = sel ? bus_b.busy      : bus_a.busy;
   assign obs_done      = sel ? bus_b.done      : bus_a.done;
   assign obs_rd_en     = sel ? bus_b.rd_en     : bus_a.rd_en;
   assign obs_h_zero    = sel ? bus_b.h_zero    : bus_a.h_zero;
   assign obs_wr_en     = sel ? bus_b.wr_en     : bus_a.wr_en;
   assign obs_rd_addr_c = sel ? bus_b.rd_addr_c : bus_a.rd_addr_c;
   assign obs_rd_addr_h = sel ? bus_b.rd_addr_h : bus_a.rd_addr_h;
   assign obs_wr_addr   = sel ? bus_b.wr_addr   : bus_a.wr_addr;
   assign obs_step_idx  = sel ? bus_b.step_idx  : bus_a.step_idx;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"},   obs_busy, 0);
      chk({tag, "_done"},   obs_done, 0);
      chk({tag, "_rd_en"},  obs_rd_en, 0);
      chk({tag, "_wr_en"},  obs_wr_en, 0);
      chk({tag, "_h_zero"}, obs_h_zero, 0);
   endtask

   // Slot kinds: 0 = read row, 1 = drain, 2 = step bubble, 3 = done pulse.
   task automatic run_seq(input int nh, input int ts, input int dl, input int stall_pct,
                          input int f_at, input int f_len, input bit start_hold,
                          input int abort_at, output int done_cyc, output int n_rd,
                          output int n_wr);
      int s_kind[$];
      int s_t[$];
      int s_r[$];
      int p_addr[$];
      int p_cnt[$];
      int kind, t, r;
      bit stl, tail;
      done_cyc = -1;
      n_rd = 0;
      n_wr = 0;
      for (int ti = 0; ti < ts; ti++) begin
         for (int ri = 0; ri < nh; ri++) begin
            s_kind.push_back(0); s_t.push_back(ti); s_r.push_back(ri);
         end
         for (int di = 0; di < dl; di++) begin
            s_kind.push_back(1); s_t.push_back(ti); s_r.push_back(0);
         end
         s_kind.push_back((ti == ts - 1) ? 3 : 2); s_t.push_back(ti); s_r.push_back(0);
      end
      @(negedge clk);
      cyc = 0;
      start_v = 1'b1;
      stall_v = 1'b0;
      #1;
      chk_idle("pre_start");
      for (int c = 1; c <= 4000; c++) begin
         @(negedge clk);
         cyc = c;
         start_v = start_hold;
         stl = ((c >= f_at) && (c < f_at + f_len)) || ($urandom_range(99) < stall_pct);
         stall_v = stl;
         if (c == abort_at) rst = 1'b1;
         #1;
         kind = s_kind[0];
         t = s_t[0];
         r = s_r[0];
         tail = (p_cnt.size() > 0) && (p_cnt[0] >= dl);
         chk("busy", obs_busy, 1);
         chk("done", obs_done, (kind == 3) ? 1 : 0);
         chk("rd_en", obs_rd_en, (kind == 0 && !stl) ? 1 : 0);
         chk("h_zero", obs_h_zero, (t == 0) ? 1 : 0);
         chk("step_idx", obs_step_idx, t);
         if (kind == 0) begin
            chk("rd_addr_c", obs_rd_addr_c, t * nh + r);
            chk("rd_addr_h", obs_rd_addr_h, (t == 0) ? 0 : (t - 1) * nh + r);
         end
         if (tail) chk("wr_addr", obs_wr_addr, p_addr[0]);
         chk("wr_en", obs_wr_en, (tail && !stl) ? 1 : 0);
         if (obs_rd_en === 1'b1) n_rd++;
         if (obs_wr_en === 1'b1) n_wr++;
         if (kind == 3) done_cyc = c;
         if (!stl) begin
            if (tail) begin
               void'(p_addr.pop_front());
               void'(p_cnt.pop_front());
            end
            foreach (p_cnt[i]) p_cnt[i]++;
            if (kind == 0) begin
               p_addr.push_back(t * nh + r);
               p_cnt.push_back(1);
            end
         end
         if (kind >= 2 || !stl) begin
            void'(s_kind.pop_front());
            void'(s_t.pop_front());
            void'(s_r.pop_front());
         end
         if (c == abort_at || s_kind.size() == 0) break;
      end
      if (abort_at < 0) chk("seq_finished", s_kind.size(), 0);
   endtask

   int dc, nr, nw;

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      sel = 1'b0;
      chk_idle("reset_a");
      chk("reset_a_rd_addr_c", obs_rd_addr_c, 0);
      chk("reset_a_wr_addr", obs_wr_addr, 0);
      sel = 1'b1;
      #1;
      chk_idle("reset_b");
      chk("reset_b_rd_addr_h", obs_rd_addr_h, 0);

      sel = 1'b0;
      run_seq(53, 7, 1, 0, -1, 0, 1'b0, -1, dc, nr, nw);
      $display("run a_plain: done_cyc=%0d reads=%0d writes=%0d", dc, nr, nw);
      chk("a_plain_done_cyc", dc, 385);
      chk("a_plain_reads", nr, SEQ_STOP);
      chk("a_plain_writes", nw, SEQ_STOP);

      run_seq(53, 7, 1, 0, 121, 3, 1'b1, -1, dc, nr, nw);
      $display("run a_stall3_hold_start: done_cyc=%0d reads=%0d writes=%0d", dc, nr, nw);
      chk("a_stall3_done_cyc", dc, 388);
      chk("a_stall3_writes", nw, SEQ_STOP);

      run_seq(53, 7, 1, 0, 54, 2, 1'b0, -1, dc, nr, nw);
      $display("run a_drain_stall: done_cyc=%0d reads=%0d writes=%0d", dc, nr, nw);
      chk("a_drain_stall_done_cyc", dc, 387);

      run_seq(53, 7, 1, 25, -1, 0, 1'b0, -1, dc, nr, nw);
      $display("run a_random_stall: done_cyc=%0d reads=%0d writes=%0d", dc, nr, nw);
      chk("a_rand_reads", nr, SEQ_STOP);
      chk("a_rand_writes", nw, SEQ_STOP);

      run_seq(53, 7, 1, 0, -1, 0, 1'b0, 186, dc, nr, nw);
      @(negedge clk);
      rst = 1'b0;
      start_v = 1'b0;
      stall_v = 1'b0;
      #1;
      $display("run a_abort: reset at cycle 186, reads_before=%0d", nr);
      chk_idle("abort");
      chk("abort_rd_addr_c", obs_rd_addr_c, 0);
      chk("abort_rd_addr_h", obs_rd_addr_h, 0);
      chk("abort_wr_addr", obs_wr_addr, 0);
      chk("abort_step_idx", obs_step_idx, 0);

      run_seq(53, 7, 1, 0, -1, 0, 1'b0, -1, dc, nr, nw);
      $display("run a_replay: done_cyc=%0d reads=%0d writes=%0d", dc, nr, nw);
      chk("a_replay_done_cyc", dc, 385);

      sel = 1'b1;
      run_seq(5, 2, 4, 0, -1, 0, 1'b0, -1, dc, nr, nw);
      $display("run b_plain: done_cyc=%0d reads=%0d writes=%0d", dc, nr, nw);
      chk("b_plain_done_cyc", dc, 20);
      chk("b_plain_writes", nw, 10);

      run_seq(5, 2, 4, 30, -1, 0, 1'b1, -1, dc, nr, nw);
      $display("run b_random_stall: done_cyc=%0d reads=%0d writes=%0d", dc, nr, nw);
      chk("b_rand_reads", nr, 10);
      chk("b_rand_writes", nw, 10);

      @(negedge clk);
      start_v = 1'b0;
      stall_v = 1'b0;
      #1;
      chk_idle("final_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
